fifo_ovf: RTL
=============

Name: fifo_ovf

Overview:
- Parametrised successor to the team's simple FIFO: a single-clock, first-word-fall-through buffer.
- Full 2**DEPTH capacity with no wasted slot.
- Selectable drop/overwrite-on-full, flush, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags.
- Sits between byte-stream producers and consumers (e.g. coax receive path to host interface).

Parameters:
- WIDTH, 8, data word width in bits
- DEPTH, 5, log2 of entry count; capacity is 2**DEPTH
- AF_THRESH, 2**DEPTH-4, almost_full asserts when occupancy >= AF_THRESH
- AE_THRESH, 3, almost_empty asserts when occupancy <= AE_THRESH

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- mode  in  1  0 = drop write when full; 1 = overwrite oldest entry when full
- flush  in  1  synchronous empty of the FIFO
- clear_err  in  1  clears overflow and underflow
- wen  in  1  write enable
- ren  in  1  read/pop enable
- write  in  WIDTH  write data
- read  out  WIDTH  head-of-queue data (first word fall-through)
- empty  out  1  occupancy == 0
- full  out  1  occupancy == 2**DEPTH
- occupancy  out  DEPTH+1  entries held, 0..2**DEPTH
- almost_full  out  1  occupancy >= AF_THRESH
- almost_empty  out  1  occupancy <= AE_THRESH
- overflow  out  1  sticky: a write was dropped or overwrote data
- underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Pointers: wr_ptr and rd_ptr are DEPTH+1 bits and wrap modulo 2**(DEPTH+1); the memory index is the low DEPTH bits.
- Pointer arithmetic: occupancy = wr_ptr - rd_ptr, modulo 2**(DEPTH+1).
- Status: full when the MSBs differ and the low bits are equal.
- Reset (asserted low, any time, including mid-transfer): pointers = 0, overflow = underflow = 0.
- Reset output values: empty=1, full=0, occupancy=0, almost_full=0, almost_empty=1. Memory is not reset; read is undefined until the first write.
- Derivation: all status outputs are combinational from the registered pointers and flags.
- Latency: a write at edge N is visible on read/empty/occupancy after edge N. A pop at edge N presents the next word after edge N.
- Priority at each edge: flush > write/read.
- flush: pointers = 0; wen and ren are ignored that cycle. Sticky flags are unchanged.
- Not full, wen=1: mem[wr] <= write, wr_ptr++.
- Not empty, ren=1: rd_ptr++.
- Empty, ren=1: no pop; underflow <= 1. If wen is also 1, the write proceeds normally.
- Full, wen=1, ren=1: write and pop both proceed; occupancy stays 2**DEPTH; no overflow.
- Full, wen=1, ren=0, mode=0: write dropped, pointers unchanged; overflow <= 1.
- Full, wen=1, ren=0, mode=1: mem[wr] <= write, wr_ptr++, rd_ptr++ (oldest entry discarded); overflow <= 1.
- clear_err=1 clears both sticky flags, but a new error event in the same cycle wins (flag stays 1).
- Thresholds: AF_THRESH must satisfy 1..2**DEPTH; AE_THRESH must satisfy 0..2**DEPTH-1. Elaboration fails otherwise.

Optional Feature:
- Macro: FIFO_OVF_HWM_EN.
- When defined, adds output hwm [DEPTH:0], a high-water mark equal to the maximum occupancy reached.
  - Updated one cycle after occupancy changes (registered compare).
  - Cleared to 0 by reset and by clear_err.
  - flush does not clear it.
- When undefined, the port and its logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package fifo_pkg holds:
  - the occupancy-width helper function (DEPTH+1)
  - mode encodings MODE_DROP=0 and MODE_OVERWRITE=1
  - threshold-legality check constants
- One natural sub-module, fifo_ovf_ptr: pointer pair, occupancy, full/empty, and the next-pointer logic for all the cases above.
- Memory array and sticky flags stay in the top level.

Test Plan:
- Reset, then write 0x01..0x20 (DEPTH=5, 32 words) -> full=1, occupancy=32, almost_full asserted from occupancy 28; read shows 0x01; pop all 32 -> data 0x01..0x20 in order, empty=1.
- Full, mode=0, write 0xAA -> dropped, overflow=1; pop 32 -> 0x01..0x20, no 0xAA.
- Full, mode=1, write 0xBB -> overflow=1, occupancy=32, read=0x02; final pop yields 0xBB.
- Empty, ren=1 with wen=1, write 0x5C -> underflow=1, occupancy=1, read=0x5C; clear_err with simultaneous empty pop -> underflow remains 1.
- Occupancy 10, flush with wen=1 and ren=1 -> occupancy=0, empty=1, flags unchanged; async reset mid-burst -> all outputs at reset values before the next edge.
- FIFO_OVF_HWM_EN defined: fill to 17, drain to 3 -> hwm=17; clear_err -> hwm=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for fifo_ovf: occupancy width helper, full-behaviour
// mode encoding and threshold legality checks.
package fifo_pkg;

    typedef enum logic {
        MODE_DROP      = 1'b0,
        MODE_OVERWRITE = 1'b1
    } mode_e;

    localparam int unsigned AF_THRESH_MIN = 1;
    localparam int unsigned AE_THRESH_MIN = 0;

    function automatic int unsigned occ_w(input int unsigned depth);
        return depth + 1;
    endfunction

    function automatic bit af_thresh_ok(input int unsigned depth, input int unsigned th);
        return (th >= AF_THRESH_MIN) && (th <= (2 ** depth));
    endfunction

    function automatic bit ae_thresh_ok(input int unsigned depth, input int unsigned th);
        return (th >= AE_THRESH_MIN) && (th <= (2 ** depth) - 1);
    endfunction

endpackage

// File: rtl/fifo_ovf_ptr.sv
// Pointer pair for fifo_ovf: extra-MSB wrap pointers, occupancy, full/empty
// and next-pointer decisions for drop, overwrite, flush and error events.
module fifo_ovf_ptr
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_flush,
    input  logic                      i_wen,
    input  logic                      i_ren,
    input  logic                      i_mode,
    output logic [DEPTH-1:0]          o_wr_idx,
    output logic [DEPTH-1:0]          o_rd_idx,
    output logic [occ_w(DEPTH)-1:0]   o_occupancy,
    output logic                      o_full,
    output logic                      o_empty,
    output logic                      o_do_write,
    output logic                      o_ovf_evt,
    output logic                      o_udf_evt
);

    logic [DEPTH:0] r_wr_ptr;
    logic [DEPTH:0] r_rd_ptr;
    logic           w_full;
    logic           w_empty;
    logic           w_blocked;
    logic           w_overwrite;
    logic           w_pop;
    logic           w_adv_rd;

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[DEPTH] != r_rd_ptr[DEPTH]) &&
                         (r_wr_ptr[DEPTH-1:0] == r_rd_ptr[DEPTH-1:0]);
    assign w_overwrite = (i_mode == MODE_OVERWRITE);

    // A full FIFO only blocks a write when no pop frees a slot in the same cycle.
    assign w_blocked  = w_full && !i_ren;
    assign w_pop      = !i_flush && i_ren && !w_empty;
    assign o_do_write = !i_flush && i_wen && (!w_blocked || w_overwrite);
    assign w_adv_rd   = w_pop || (o_do_write && w_blocked);
    assign o_ovf_evt  = !i_flush && i_wen && w_blocked;
    assign o_udf_evt  = !i_flush && i_ren && w_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (o_do_write) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_adv_rd)   r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign o_wr_idx    = r_wr_ptr[DEPTH-1:0];
    assign o_rd_idx    = r_rd_ptr[DEPTH-1:0];
    assign o_occupancy = r_wr_ptr - r_rd_ptr;
    assign o_full      = w_full;
    assign o_empty     = w_empty;

endmodule

// File: rtl/fifo_ovf.sv
// Single-clock first-word-fall-through FIFO with drop/overwrite on full,
// flush, almost flags and sticky errors. FIFO_OVF_HWM_EN adds a high-water mark.
module fifo_ovf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 5,
    parameter int unsigned AF_THRESH = 2 ** DEPTH - 4,
    parameter int unsigned AE_THRESH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic             flush,
    input  logic             clear_err,
    input  logic             wen,
    input  logic             ren,
    input  logic [WIDTH-1:0] write,
    output logic [WIDTH-1:0] read,
    output logic             empty,
    output logic             full,
    output logic [DEPTH:0]   occupancy,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
`ifdef FIFO_OVF_HWM_EN
    ,
    output logic [DEPTH:0]   hwm
`endif
);

    if (!af_thresh_ok(DEPTH, AF_THRESH)) begin : g_bad_af
        $error("fifo_ovf: AF_THRESH out of range 1..2**DEPTH");
    end
    if (!ae_thresh_ok(DEPTH, AE_THRESH)) begin : g_bad_ae
        $error("fifo_ovf: AE_THRESH out of range 0..2**DEPTH-1");
    end

    localparam logic [DEPTH:0] AF_LVL = (DEPTH + 1)'(AF_THRESH);
    localparam logic [DEPTH:0] AE_LVL = (DEPTH + 1)'(AE_THRESH);

    logic [WIDTH-1:0] r_mem [2 ** DEPTH];
    logic [DEPTH-1:0] w_wr_idx;
    logic [DEPTH-1:0] w_rd_idx;
    logic [DEPTH:0]   w_occ;
    logic             w_do_write;
    logic             w_ovf_evt;
    logic             w_udf_evt;
    logic             r_overflow;
    logic             r_underflow;

    fifo_ovf_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .i_clk       (clk),
        .i_rst_n     (reset),
        .i_flush     (flush),
        .i_wen       (wen),
        .i_ren       (ren),
        .i_mode      (mode),
        .o_wr_idx    (w_wr_idx),
        .o_rd_idx    (w_rd_idx),
        .o_occupancy (w_occ),
        .o_full      (full),
        .o_empty     (empty),
        .o_do_write  (w_do_write),
        .o_ovf_evt   (w_ovf_evt),
        .o_udf_evt   (w_udf_evt)
    );

    always_ff @(posedge clk) begin
        if (w_do_write) r_mem[w_wr_idx] <= write;
    end

    // A new error event in the same cycle as clear_err keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_evt || (r_overflow && !clear_err);
            r_underflow <= w_udf_evt || (r_underflow && !clear_err);
        end
    end

    assign read         = r_mem[w_rd_idx];
    assign occupancy    = w_occ;
    assign almost_full  = (w_occ >= AF_LVL);
    assign almost_empty = (w_occ <= AE_LVL);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

`ifdef FIFO_OVF_HWM_EN
    logic [DEPTH:0] r_hwm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hwm <= '0;
        end else if (clear_err) begin
            r_hwm <= '0;
        end else if (w_occ > r_hwm) begin
            r_hwm <= w_occ;
        end
    end

    assign hwm = r_hwm;
`endif

endmodule
